// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory request/response bus between fetch stage and imem
interface fetch_stage_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register and stall hold buffer
// Optional macro FETCH_STALL_CNT_EN adds a saturating stall-cycle counter output.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PCWrite,
    input  logic             IFIDWrite,
    input  logic             branchTaken,
    input  logic [15:0]      branchTarget,
    fetch_stage_if.master    imem,
    output logic [15:0]      ifid_instr,
    output logic [15:0]      ifid_pc,
    output logic             ifid_valid
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]      stall_count
`endif
);

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_ifid_instr;
    logic [15:0] r_ifid_pc;
    logic        r_ifid_valid;
    logic [15:0] r_hold_instr;
    logic [15:0] r_hold_pc;

    state_t      w_state_n;
    logic [15:0] w_pc_n;
    logic [15:0] w_ifid_instr_n;
    logic [15:0] w_ifid_pc_n;
    logic        w_ifid_valid_n;
    logic [15:0] w_hold_instr_n;
    logic [15:0] w_hold_pc_n;
    logic        w_stall;
    logic [15:0] w_pc_inc;

    assign w_stall  = !PCWrite || !IFIDWrite;
    assign w_pc_inc = r_pc + 16'd1;

    always_comb begin
        w_state_n      = r_state;
        w_pc_n         = r_pc;
        w_ifid_instr_n = r_ifid_instr;
        w_ifid_pc_n    = r_ifid_pc;
        w_ifid_valid_n = r_ifid_valid;
        w_hold_instr_n = r_hold_instr;
        w_hold_pc_n    = r_hold_pc;

        if (branchTaken) begin
            // Redirect wins over everything: held word and same-cycle ack are dropped.
            w_pc_n         = branchTarget;
            w_ifid_valid_n = 1'b0;
            w_state_n      = S_REQ;
        end else begin
            unique case (r_state)
                S_REQ: begin
                    if (imem.imem_ack) begin
                        if (!w_stall) begin
                            w_ifid_instr_n = imem.imem_rdata;
                            w_ifid_pc_n    = r_pc;
                            w_ifid_valid_n = 1'b1;
                            w_pc_n         = w_pc_inc;
                        end else begin
                            w_hold_instr_n = imem.imem_rdata;
                            w_hold_pc_n    = r_pc;
                            w_state_n      = S_HOLD;
                        end
                    end else if (!w_stall) begin
                        // Bubble only when nothing is stalled, so a valid IF/ID word survives any stall.
                        w_ifid_valid_n = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!w_stall) begin
                        w_ifid_instr_n = r_hold_instr;
                        w_ifid_pc_n    = r_hold_pc;
                        w_ifid_valid_n = 1'b1;
                        w_pc_n         = w_pc_inc;
                        w_state_n      = S_REQ;
                    end
                end
                default: w_state_n = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_ifid_instr <= 16'h0000;
            r_ifid_pc    <= 16'h0000;
            r_ifid_valid <= 1'b0;
            r_hold_instr <= 16'h0000;
            r_hold_pc    <= 16'h0000;
        end else begin
            r_state      <= w_state_n;
            r_pc         <= w_pc_n;
            r_ifid_instr <= w_ifid_instr_n;
            r_ifid_pc    <= w_ifid_pc_n;
            r_ifid_valid <= w_ifid_valid_n;
            r_hold_instr <= w_hold_instr_n;
            r_hold_pc    <= w_hold_pc_n;
        end
    end

    assign imem.imem_req  = reset && (r_state == S_REQ);
    assign imem.imem_addr = r_pc;
    assign ifid_instr     = r_ifid_instr;
    assign ifid_pc        = r_ifid_pc;
    assign ifid_valid     = r_ifid_valid;

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_count <= 16'h0000;
        end else if (w_stall && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif

endmodule
